burst_search_ctrl: RTL and testbench

//  Sequencer and configuration owner for one burst_search datapath instance.
//  - Accepts (n, threshold) configs through a valid/ready handshake.
//  - Clears the datapath, then waits out the window fill, and only then arms detection.
//  - Qualifies raw burst_detected with a consecutive-cycle hold and a holdoff window.
//  - Emits timestamped events through a one-entry valid/ready output buffer.

---
 rtl/burst_search_ctrl_pkg.sv | 28 ++
 rtl/burst_search_ctrl_if.sv | 32 +++
 rtl/burst_search_ctrl_evt_buf.sv | 48 ++++
 rtl/burst_search_ctrl.sv | 168 ++++++++++++++++
 tb/tb_burst_search_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/burst_search_ctrl_pkg.sv
// Shared definitions for the burst_search sequencer: state encoding,
// default timing constants and small elaboration-time helpers.
package burst_search_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_FILL    = 3'd2,
        ST_ARMED   = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_e;

    localparam int DEF_CLEAR_CYCLES = 2;
    localparam int DEF_HOLD         = 3;
    localparam int DEF_HOLDOFF      = 16;

    // Width of the datapath stage-select field; never narrower than one bit.
    function automatic int size_n(input int shift_len);
        return (shift_len > 1) ? $clog2(shift_len) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/burst_search_ctrl_if.sv
// Config request and event output handshakes of the burst_search sequencer.
// master = the host side (issues configs, consumes events),
// slave  = the controller.
interface burst_search_ctrl_if
    import burst_search_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIZE_N = size_n(8),
    parameter int TS_W   = 16
);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [SIZE_N-1:0] cfg_n;
    logic [WIDTH-1:0]  cfg_threshold;

    logic              evt_valid;
    logic              evt_ready;
    logic [TS_W-1:0]   evt_ts;
    logic              evt_overflow;

    modport master (
        output cfg_valid, cfg_n, cfg_threshold, evt_ready,
        input  cfg_ready, evt_valid, evt_ts, evt_overflow
    );

    modport slave (
        input  cfg_valid, cfg_n, cfg_threshold, evt_ready,
        output cfg_ready, evt_valid, evt_ts, evt_overflow
    );

endinterface

// File: rtl/burst_search_ctrl_evt_buf.sv
// Single-entry event buffer with valid/ready output and a sticky drop flag.
// A capture that lands while the entry is occupied and not being popped is
// discarded; a capture coinciding with a pop simply reloads the entry.
module burst_evt_buf
    import burst_search_pkg::*;
#(
    parameter int TS_W = 16
) (
    input  logic            clock,
    input  logic            ss_n,
    input  logic            capture,
    input  logic [TS_W-1:0] capture_ts,
    input  logic            clr_overflow,
    input  logic            ready,
    output logic            valid,
    output logic [TS_W-1:0] ts,
    output logic            overflow
);

    logic pop;

    assign pop = valid & ready;

    // Entry load / pop; the held timestamp stays put after a pop.
    always_ff @(posedge clock or posedge ss_n) begin
        if (ss_n) begin
            valid <= 1'b0;
            ts    <= '0;
        end else if (capture && (!valid || pop)) begin
            valid <= 1'b1;
            ts    <= capture_ts;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

    // Sticky drop indicator, cleared only when a new config is accepted.
    always_ff @(posedge clock or posedge ss_n) begin
        if (ss_n) begin
            overflow <= 1'b0;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end else if (capture && valid && !pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/burst_search_ctrl.sv
// Sequencer and configuration owner for one burst_search datapath.
// Owns the (n, threshold) registers, clears the datapath and waits for the
// delay line to fill before arming, qualifies raw burst hits with a
// consecutive-cycle hold plus a holdoff window, and timestamps events.
module burst_search_ctrl
    import burst_search_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SHIFT_LEN    = 8,
    parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
    parameter int FILL_MARGIN  = 1,
    parameter int HOLD         = DEF_HOLD,
    parameter int HOLDOFF      = DEF_HOLDOFF,
    parameter int TS_W         = 16,
    localparam int SIZE_N      = size_n(SHIFT_LEN)
) (
    input  logic              clock,
    input  logic              ss_n,
    input  logic              en,
    input  logic              burst_in,
    output logic              srch_rst,
    output logic [SIZE_N-1:0] srch_n,
    output logic [WIDTH-1:0]  srch_threshold,
    output logic              armed,
    burst_search_ctrl_if.slave bus
);

    localparam logic [2:0] IDLE    = ST_IDLE;
    localparam logic [2:0] CLEAR   = ST_CLEAR;
    localparam logic [2:0] FILL    = ST_FILL;
    localparam logic [2:0] ARMED   = ST_ARMED;
    localparam logic [2:0] HOLDOFF_ST = ST_HOLDOFF;

    // One shared phase counter covers CLEAR, FILL and HOLDOFF durations.
    localparam int CNT_MAX = max3(SHIFT_LEN + FILL_MARGIN, CLEAR_CYCLES, HOLDOFF);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RUN_W   = $clog2(HOLD + 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] fill_len;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_inc;
    logic [TS_W-1:0]  ts;
    logic             cfg_fire;
    logic             hit;

    assign cfg_fire = bus.cfg_valid & bus.cfg_ready;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign run_inc  = run + RUN_W'(1);
    assign fill_len = CNT_W'(srch_n) + CNT_W'(FILL_MARGIN);

    // The HOLD-th consecutive burst sample while armed; a concurrent config
    // accept or enable drop wins and suppresses the event.
    assign hit = (state == ARMED) && en && !cfg_fire && burst_in &&
                 (run == RUN_W'(HOLD - 1));

    assign srch_rst      = (state == IDLE) || (state == CLEAR);
    assign armed         = (state == ARMED) || (state == HOLDOFF_ST);
    assign bus.cfg_ready = (state == IDLE) || (state == ARMED) || (state == HOLDOFF_ST);

    // Sequencer: enable drop beats config accept, which beats normal flow.
    always_ff @(posedge clock or posedge ss_n) begin
        if (ss_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!en) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (cfg_fire) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
                CLEAR: begin
                    if (cnt_inc == CNT_W'(CLEAR_CYCLES)) begin
                        cnt   <= '0;
                        state <= (fill_len == '0) ? ARMED : FILL;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                FILL: begin
                    if (cnt_inc == fill_len) begin
                        cnt   <= '0;
                        state <= ARMED;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ARMED: begin
                    cnt <= '0;
                    if (hit && (HOLDOFF > 0)) begin
                        state <= HOLDOFF_ST;
                    end
                end
                HOLDOFF_ST: begin
                    if (cnt_inc == CNT_W'(HOLDOFF)) begin
                        cnt   <= '0;
                        state <= ARMED;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Datapath configuration, latched on every accepted request.
    always_ff @(posedge clock or posedge ss_n) begin
        if (ss_n) begin
            srch_n         <= '0;
            srch_threshold <= '0;
        end else if (cfg_fire) begin
            srch_n         <= bus.cfg_n;
            srch_threshold <= bus.cfg_threshold;
        end
    end

    // Consecutive-hit run counter; only counts while armed and saturates at
    // HOLD so a held burst with no holdoff yields one event per run.
    always_ff @(posedge clock or posedge ss_n) begin
        if (ss_n) begin
            run <= '0;
        end else if (cfg_fire || !en || (state != ARMED) || !burst_in) begin
            run <= '0;
        end else if (hit && (HOLDOFF > 0)) begin
            run <= '0;
        end else if (run != RUN_W'(HOLD)) begin
            run <= run_inc;
        end
    end

    // Free-running timestamp, frozen in IDLE and restarted by a config.
    always_ff @(posedge clock or posedge ss_n) begin
        if (ss_n) begin
            ts <= '0;
        end else if (cfg_fire) begin
            ts <= '0;
        end else if (state != IDLE) begin
            ts <= ts + TS_W'(1);
        end
    end

    burst_evt_buf #(
        .TS_W (TS_W)
    ) u_evt_buf (
        .clock        (clock),
        .ss_n         (ss_n),
        .capture      (hit),
        .capture_ts   (ts),
        .clr_overflow (cfg_fire),
        .ready        (bus.evt_ready),
        .valid        (bus.evt_valid),
        .ts           (bus.evt_ts),
        .overflow     (bus.evt_overflow)
    );

endmodule

// File: tb/tb_burst_search_ctrl.sv
// Bench for burst_search_ctrl with default parameters
// (CLEAR_CYCLES=2, FILL_MARGIN=1, HOLD=3, HOLDOFF=16, TS_W=16).
// Expected event timestamps go into a queue when the qualifying burst is
// driven and are popped when the DUT presents the event.
module tb_burst_search_ctrl;

    localparam int HOLD    = 3;
    localparam int HOLDOFF = 16;

    logic       clock;
    logic       ss_n;
    logic       en;
    logic       burst_in;
    logic       srch_rst;
    logic [2:0] srch_n;
    logic [7:0] srch_threshold;
    logic       armed;

    int          checks   = 0;
    int          failures = 0;
    int          ts_model = 0;
    bit          active   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    logic [15:0] first_ts;

    burst_search_ctrl_if #(.WIDTH(8), .SIZE_N(3), .TS_W(16)) bus ();

    burst_search_ctrl dut (
        .clock          (clock),
        .ss_n           (ss_n),
        .en             (en),
        .burst_in       (burst_in),
        .srch_rst       (srch_rst),
        .srch_n         (srch_n),
        .srch_threshold (srch_threshold),
        .armed          (armed),
        .bus            (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // One clock; ts_model follows the timestamp of a non-idle block.
    task automatic step();
        @(posedge clock);
        if (active) ts_model = ts_model + 1;
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drive n burst samples; the last one is the qualifying one.
    task automatic drive_burst(input int n);
        burst_in = 1'b1;
        for (int i = 0; i < n - 1; i++) step();
        exp_q.push_back(16'(ts_model));
        step();
        burst_in = 1'b0;
    endtask

    task automatic test_reset();
        ss_n = 1'b1; en = 1'b0; burst_in = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_n = '0; bus.cfg_threshold = '0; bus.evt_ready = 1'b0;
        wait_cycles(3);
        checks++; if (srch_rst !== 1'b1) begin failures++; $display("FAIL reset_srch_rst got=%0b exp=1", srch_rst); end
        checks++; if (srch_n !== 3'd0) begin failures++; $display("FAIL reset_srch_n got=%0d exp=0", srch_n); end
        checks++; if (srch_threshold !== 8'd0) begin failures++; $display("FAIL reset_thr got=%0d exp=0", srch_threshold); end
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL reset_armed got=%0b exp=0", armed); end
        checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL reset_evt_valid got=%0b exp=0", bus.evt_valid); end
        checks++; if (bus.evt_ts !== 16'd0) begin failures++; $display("FAIL reset_evt_ts got=%0d exp=0", bus.evt_ts); end
        checks++; if (bus.evt_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", bus.evt_overflow); end
        checks++; if (bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%0b exp=1", bus.cfg_ready); end
        ss_n = 1'b0;
        wait_cycles(2);
        checks++; if (srch_rst !== 1'b1 || armed !== 1'b0) begin failures++; $display("FAIL idle_hold got=%0b/%0b exp=1/0", srch_rst, armed); end
    endtask

    task automatic test_config();
        en = 1'b1; bus.cfg_valid = 1'b1; bus.cfg_n = 3'd4; bus.cfg_threshold = 8'd20;
        step();
        bus.cfg_valid = 1'b0; ts_model = 0; active = 1'b1;
        checks++; if (srch_rst !== 1'b1 || bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL cfg_clear1 got=%0b/%0b exp=1/0", srch_rst, bus.cfg_ready); end
        checks++; if (srch_n !== 3'd4 || srch_threshold !== 8'd20) begin failures++; $display("FAIL cfg_regs got=%0d/%0d exp=4/20", srch_n, srch_threshold); end
        step();
        checks++; if (srch_rst !== 1'b1) begin failures++; $display("FAIL cfg_clear2 got=%0b exp=1", srch_rst); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (srch_rst !== 1'b0 || armed !== 1'b0 || bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL cfg_fill%0d got=%0b/%0b/%0b exp=0/0/0", i, srch_rst, armed, bus.cfg_ready); end
        end
        step();
        checks++; if (armed !== 1'b1 || bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL cfg_armed got=%0b/%0b exp=1/1", armed, bus.cfg_ready); end
    endtask

    task automatic test_hold();
        burst_in = 1'b1;
        wait_cycles(2);
        burst_in = 1'b0;
        step();
        checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL short_run_evt got=%0b exp=0", bus.evt_valid); end
        // Third high sample happens 13 cycles after the config accept: ts 12.
        burst_in = 1'b1;
        wait_cycles(2);
        exp_q.push_back(16'(ts_model));
        first_ts = 16'd12;
        step();
        checks++; if (bus.evt_valid !== 1'b1) begin failures++; $display("FAIL hold_evt_valid got=%0b exp=1", bus.evt_valid); end
        exp_v = exp_q.pop_front();
        checks++; if (bus.evt_ts !== exp_v) begin failures++; $display("FAIL hold_evt_ts got=%0d exp=%0d", bus.evt_ts, exp_v); end
        checks++; if (bus.evt_ts !== first_ts) begin failures++; $display("FAIL hold_evt_ts_abs got=%0d exp=%0d", bus.evt_ts, first_ts); end
        checks++; if (armed !== 1'b1) begin failures++; $display("FAIL holdoff_armed got=%0b exp=1", armed); end
        bus.evt_ready = 1'b1;
        step();
        bus.evt_ready = 1'b0;
    endtask

    task automatic test_holdoff();
        // burst_in is still high; 15 holdoff cycles remain after the pop.
        for (int i = 0; i < HOLDOFF - 1; i++) begin
            checks++; if (armed !== 1'b1 || bus.evt_valid !== 1'b0) begin failures++; $display("FAIL holdoff_cyc%0d got=%0b/%0b exp=1/0", i, armed, bus.evt_valid); end
            step();
        end
        for (int i = 0; i < HOLD; i++) begin
            checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL rearm_early%0d got=%0b exp=0", i, bus.evt_valid); end
            if (i == HOLD - 1) exp_q.push_back(first_ts + 16'(HOLDOFF + HOLD));
            step();
        end
        burst_in = 1'b0;
        checks++; if (bus.evt_valid !== 1'b1) begin failures++; $display("FAIL rearm_evt_valid got=%0b exp=1", bus.evt_valid); end
        exp_v = exp_q.pop_front();
        checks++; if (bus.evt_ts !== exp_v) begin failures++; $display("FAIL rearm_evt_ts got=%0d exp=%0d", bus.evt_ts, exp_v); end
        bus.evt_ready = 1'b1;
        step();
        bus.evt_ready = 1'b0;
        checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL pop_clears got=%0b exp=0", bus.evt_valid); end
    endtask

    task automatic test_overflow();
        wait_cycles(20);
        drive_burst(HOLD);
        checks++; if (bus.evt_valid !== 1'b1 || bus.evt_ts !== exp_q[0]) begin failures++; $display("FAIL ovf_first got=%0b/%0d exp=1/%0d", bus.evt_valid, bus.evt_ts, exp_q[0]); end
        wait_cycles(20);
        burst_in = 1'b1;
        wait_cycles(HOLD);
        burst_in = 1'b0;
        checks++; if (bus.evt_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", bus.evt_overflow); end
        checks++; if (bus.evt_valid !== 1'b1 || bus.evt_ts !== exp_q[0]) begin failures++; $display("FAIL ovf_kept got=%0b/%0d exp=1/%0d", bus.evt_valid, bus.evt_ts, exp_q[0]); end
        wait_cycles(20);
        burst_in = 1'b1;
        wait_cycles(HOLD - 1);
        exp_v = exp_q.pop_front();
        checks++; if (bus.evt_valid !== 1'b1 || bus.evt_ts !== exp_v) begin failures++; $display("FAIL ovf_pop_first got=%0b/%0d exp=1/%0d", bus.evt_valid, bus.evt_ts, exp_v); end
        bus.evt_ready = 1'b1;
        exp_q.push_back(16'(ts_model));
        step();
        bus.evt_ready = 1'b0;
        burst_in = 1'b0;
        checks++; if (bus.evt_valid !== 1'b1) begin failures++; $display("FAIL reload_valid got=%0b exp=1", bus.evt_valid); end
        exp_v = exp_q.pop_front();
        checks++; if (bus.evt_ts !== exp_v) begin failures++; $display("FAIL reload_ts got=%0d exp=%0d", bus.evt_ts, exp_v); end
        checks++; if (bus.evt_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", bus.evt_overflow); end
        bus.evt_ready = 1'b1;
        step();
        bus.evt_ready = 1'b0;
        checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL reload_pop got=%0b exp=0", bus.evt_valid); end
    endtask

    task automatic test_enable();
        checks++; if (bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL holdoff_cfg_ready got=%0b exp=1", bus.cfg_ready); end
        bus.cfg_valid = 1'b1; bus.cfg_n = 3'd2; bus.cfg_threshold = 8'd50;
        step();
        bus.cfg_valid = 1'b0; ts_model = 0;
        checks++; if (bus.evt_overflow !== 1'b0) begin failures++; $display("FAIL cfg_clr_ovf got=%0b exp=0", bus.evt_overflow); end
        checks++; if (srch_rst !== 1'b1 || srch_n !== 3'd2) begin failures++; $display("FAIL cfg2_clear got=%0b/%0d exp=1/2", srch_rst, srch_n); end
        wait_cycles(2);
        checks++; if (srch_rst !== 1'b0 || armed !== 1'b0) begin failures++; $display("FAIL cfg2_fill got=%0b/%0b exp=0/0", srch_rst, armed); end
        en = 1'b0;
        step();
        active = 1'b0;
        checks++; if (srch_rst !== 1'b1 || armed !== 1'b0 || bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL en_drop_fill got=%0b/%0b/%0b exp=1/0/1", srch_rst, armed, bus.cfg_ready); end
        wait_cycles(3);
        checks++; if (srch_rst !== 1'b1) begin failures++; $display("FAIL en_idle got=%0b exp=1", srch_rst); end
        en = 1'b1;
        step();
        active = 1'b1;
        checks++; if (srch_rst !== 1'b1) begin failures++; $display("FAIL replay_clear1 got=%0b exp=1", srch_rst); end
        step();
        checks++; if (srch_rst !== 1'b1) begin failures++; $display("FAIL replay_clear2 got=%0b exp=1", srch_rst); end
        step();
        for (int i = 0; i < 3; i++) begin
            checks++; if (srch_rst !== 1'b0 || armed !== 1'b0) begin failures++; $display("FAIL replay_fill%0d got=%0b/%0b exp=0/0", i, srch_rst, armed); end
            step();
        end
        checks++; if (armed !== 1'b1 || srch_n !== 3'd2 || srch_threshold !== 8'd50) begin failures++; $display("FAIL replay_armed got=%0b/%0d/%0d exp=1/2/50", armed, srch_n, srch_threshold); end
        drive_burst(HOLD);
        exp_v = exp_q.pop_front();
        checks++; if (bus.evt_valid !== 1'b1 || bus.evt_ts !== exp_v) begin failures++; $display("FAIL replay_evt got=%0b/%0d exp=1/%0d", bus.evt_valid, bus.evt_ts, exp_v); end
        en = 1'b0;
        step();
        active = 1'b0;
        checks++; if (srch_rst !== 1'b1 || armed !== 1'b0) begin failures++; $display("FAIL en_drop_holdoff got=%0b/%0b exp=1/0", srch_rst, armed); end
        checks++; if (bus.evt_valid !== 1'b1) begin failures++; $display("FAIL en_drop_keeps_evt got=%0b exp=1", bus.evt_valid); end
        bus.evt_ready = 1'b1;
        step();
        bus.evt_ready = 1'b0;
        bus.cfg_valid = 1'b1; bus.cfg_n = 3'd6; bus.cfg_threshold = 8'd7;
        step();
        bus.cfg_valid = 1'b0; ts_model = 0;
        checks++; if (srch_n !== 3'd6 || srch_threshold !== 8'd7) begin failures++; $display("FAIL latch_idle_cfg got=%0d/%0d exp=6/7", srch_n, srch_threshold); end
        step();
        checks++; if (srch_rst !== 1'b1 || armed !== 1'b0 || bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL latch_stays_idle got=%0b/%0b/%0b exp=1/0/1", srch_rst, armed, bus.cfg_ready); end
        en = 1'b1;
        step();
        active = 1'b1;
    endtask

    task automatic test_cfg_hold();
        int waited;
        waited = 0;
        bus.cfg_valid = 1'b1; bus.cfg_n = 3'd3; bus.cfg_threshold = 8'd9;
        while (armed !== 1'b1 && waited < 40) begin
            checks++; if (bus.cfg_ready !== 1'b0 || srch_n !== 3'd6) begin failures++; $display("FAIL cfg_held%0d got=%0b/%0d exp=0/6", waited, bus.cfg_ready, srch_n); end
            waited++;
            step();
        end
        checks++; if (waited != 9) begin failures++; $display("FAIL cfg_held_len got=%0d exp=9", waited); end
        checks++; if (bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL cfg_ready_armed got=%0b exp=1", bus.cfg_ready); end
        step();
        bus.cfg_valid = 1'b0; ts_model = 0;
        checks++; if (srch_rst !== 1'b1 || srch_n !== 3'd3 || srch_threshold !== 8'd9) begin failures++; $display("FAIL cfg_held_accept got=%0b/%0d/%0d exp=1/3/9", srch_rst, srch_n, srch_threshold); end
        wait_cycles(6);
        checks++; if (armed !== 1'b1) begin failures++; $display("FAIL cfg3_armed got=%0b exp=1", armed); end
        drive_burst(HOLD);
        exp_v = exp_q.pop_front();
        checks++; if (bus.evt_valid !== 1'b1 || bus.evt_ts !== exp_v || exp_v !== 16'd8) begin failures++; $display("FAIL cfg3_evt got=%0b/%0d exp=1/8", bus.evt_valid, bus.evt_ts); end
        wait_cycles(3);
        checks++; if (armed !== 1'b1) begin failures++; $display("FAIL pre_async_armed got=%0b exp=1", armed); end
        #3;
        ss_n = 1'b1;
        #1;
        checks++; if (srch_rst !== 1'b1 || armed !== 1'b0 || bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL async_ctrl got=%0b/%0b/%0b exp=1/0/1", srch_rst, armed, bus.cfg_ready); end
        checks++; if (srch_n !== 3'd0 || srch_threshold !== 8'd0) begin failures++; $display("FAIL async_cfg got=%0d/%0d exp=0/0", srch_n, srch_threshold); end
        checks++; if (bus.evt_valid !== 1'b0 || bus.evt_ts !== 16'd0 || bus.evt_overflow !== 1'b0) begin failures++; $display("FAIL async_evt got=%0b/%0d/%0b exp=0/0/0", bus.evt_valid, bus.evt_ts, bus.evt_overflow); end
        en = 1'b0;
        active = 1'b0;
        step();
        ss_n = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_config();
        test_hold();
        test_holdoff();
        test_overflow();
        test_enable();
        test_cfg_hold();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
